// File: rtl/svm_pkg.sv
// Shared definitions for the SVM decision stages: LNS word layout and the
// vote FSM state encoding.
package svm_pkg;

   localparam int LNS_ZERO_BIT = 31;
   localparam int LNS_SIGN_BIT = 30;
   localparam int LNS_MAG_W    = 30;

   localparam logic [31:0] LNS_ZERO = 32'h8000_0000;

   typedef struct packed {
      logic                 zero;
      logic                 sign;
      logic [LNS_MAG_W-1:0] mag;
   } lns_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_EVAL,
      ST_VOTE,
      ST_ARGMAX,
      ST_DONE
   } state_t;

endpackage

// File: rtl/lns_sum_sign.sv
// Sign of a+b for two LNS words, without forming the sum: the operand with
// the larger log magnitude dominates when signs differ.
module lns_sum_sign
   import svm_pkg::*;
(
   input  lns_t a,
   input  lns_t b,
   output logic neg,
   output logic tie
);

   always_comb begin
      neg = 1'b0;
      tie = 1'b0;
      if (a.zero && b.zero)
         tie = 1'b1;
      else if (a.zero)
         neg = b.sign;
      else if (b.zero)
         neg = a.sign;
      else if (a.sign == b.sign)
         neg = a.sign;
      else if ($signed(a.mag) > $signed(b.mag))
         neg = a.sign;
      else if ($signed(a.mag) < $signed(b.mag))
         neg = b.sign;
      else
         tie = 1'b1;
   end

endmodule

// File: rtl/svm_vote_decision.sv
// One-vs-one vote stage: adds a per-pair bias to each decision sum, votes,
// then argmaxes the class counters. SVM_VOTE_STATUS_EN adds vote_max/vote_tie.
module svm_vote_decision
   import svm_pkg::*;
#(
   parameter  int N_CLASS = 3,
   localparam int P       = N_CLASS * (N_CLASS - 1) / 2,
   localparam int CW      = $clog2(N_CLASS),
   localparam int PW      = (P > 1) ? $clog2(P) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [31:0]   output_c,
   input  logic          sop_c,
   input  logic          bias_we,
   input  logic [PW-1:0] bias_addr,
   input  logic [31:0]   bias_data,
   output logic [CW-1:0] class_out,
   output logic          class_valid,
   output logic          busy,
   output logic          err_drop,
`ifdef SVM_VOTE_STATUS_EN
   output logic [CW-1:0] vote_max,
   output logic          vote_tie,
`endif
   output state_t        state_dbg
);

   // Handshake: sop_c is a one-cycle strobe with no back-pressure; it is
   // consumed only in IDLE, otherwise dropped and flagged on err_drop.
   state_t        state, state_nxt;
   lns_t          sum_q;
   lns_t          bias_mem [P];
   logic [PW-1:0] p_q;
   logic [CW-1:0] i_q, j_q, target_q, scan_q;
   logic [CW-1:0] best_idx_q, best_cnt_q, best_idx_nxt, best_cnt_nxt;
   logic [CW-1:0] cnt_q [N_CLASS];
   logic          neg, tie, last_pair, last_scan;
`ifdef SVM_VOTE_STATUS_EN
   logic          tie_q, tie_nxt;
`endif

   assign last_pair = (p_q == PW'(P - 1));
   assign last_scan = (scan_q == CW'(N_CLASS - 1));

   lns_sum_sign u_sign (
      .a   (sum_q),
      .b   (bias_mem[p_q]),
      .neg (neg),
      .tie (tie)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (sop_c) state_nxt = ST_EVAL;
         ST_EVAL:   state_nxt = ST_VOTE;
         ST_VOTE:   state_nxt = last_pair ? ST_ARGMAX : ST_IDLE;
         ST_ARGMAX: if (last_scan) state_nxt = ST_DONE;
         ST_DONE:   state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      busy      = (state != ST_IDLE);
      state_dbg = state;
   end

   // Strictly-greater replacement keeps ties on the lowest class index.
   always_comb begin
      best_idx_nxt = best_idx_q;
      best_cnt_nxt = best_cnt_q;
      if (scan_q == '0 || cnt_q[scan_q] > best_cnt_q) begin
         best_idx_nxt = scan_q;
         best_cnt_nxt = cnt_q[scan_q];
      end
   end

`ifdef SVM_VOTE_STATUS_EN
   always_comb begin
      tie_nxt = tie_q;
      if (scan_q == '0 || cnt_q[scan_q] > best_cnt_q)
         tie_nxt = 1'b0;
      else if (cnt_q[scan_q] == best_cnt_q)
         tie_nxt = 1'b1;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q       <= LNS_ZERO;
         p_q         <= '0;
         i_q         <= '0;
         j_q         <= CW'(1);
         target_q    <= '0;
         scan_q      <= '0;
         best_idx_q  <= '0;
         best_cnt_q  <= '0;
         class_out   <= '0;
         class_valid <= 1'b0;
         err_drop    <= 1'b0;
         for (int c = 0; c < N_CLASS; c++) cnt_q[c] <= '0;
         for (int p = 0; p < P; p++) bias_mem[p] <= LNS_ZERO;
`ifdef SVM_VOTE_STATUS_EN
         tie_q       <= 1'b0;
         vote_max    <= '0;
         vote_tie    <= 1'b0;
`endif
      end else begin
         class_valid <= 1'b0;
         if (bias_we && (32'(bias_addr) < 32'(P)))
            bias_mem[bias_addr] <= bias_data;
         if (sop_c && state != ST_IDLE)
            err_drop <= 1'b1;
         case (state)
            ST_IDLE: if (sop_c) sum_q <= output_c;
            ST_EVAL: target_q <= (neg && !tie) ? j_q : i_q;
            ST_VOTE: begin
               cnt_q[target_q] <= cnt_q[target_q] + CW'(1);
               scan_q          <= '0;
               if (last_pair) begin
                  p_q <= '0;
                  i_q <= '0;
                  j_q <= CW'(1);
               end else begin
                  p_q <= p_q + PW'(1);
                  if (j_q == CW'(N_CLASS - 1)) begin
                     i_q <= i_q + CW'(1);
                     j_q <= i_q + CW'(2);
                  end else begin
                     j_q <= j_q + CW'(1);
                  end
               end
            end
            ST_ARGMAX: begin
               best_idx_q <= best_idx_nxt;
               best_cnt_q <= best_cnt_nxt;
               scan_q     <= scan_q + CW'(1);
`ifdef SVM_VOTE_STATUS_EN
               tie_q      <= tie_nxt;
`endif
               if (last_scan) begin
                  class_out   <= best_idx_nxt;
                  class_valid <= 1'b1;
`ifdef SVM_VOTE_STATUS_EN
                  vote_max    <= best_cnt_nxt;
                  vote_tie    <= tie_nxt;
`endif
               end
            end
            ST_DONE: for (int c = 0; c < N_CLASS; c++) cnt_q[c] <= '0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_svm_vote_decision.sv
// Bench for svm_vote_decision: directed literal scenarios plus random rounds
// checked cycle-by-cycle against a behavioural vote/argmax model.
module tb_svm_vote_decision;
   import svm_pkg::*;

   localparam int N   = 3;
   localparam int P   = N * (N - 1) / 2;
   localparam int CWB = $clog2(N);
   localparam int PWB = (P > 1) ? $clog2(P) : 1;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [31:0]    output_c = '0;
   logic           sop_c = 1'b0;
   logic           bias_we = 1'b0;
   logic [PWB-1:0] bias_addr = '0;
   logic [31:0]    bias_data = '0;
   logic [CWB-1:0] class_out;
   logic           class_valid, busy, err_drop;
   state_t         state_dbg;
`ifdef SVM_VOTE_STATUS_EN
   logic [CWB-1:0] vote_max;
   logic           vote_tie;
`endif

   svm_vote_decision #(.N_CLASS(N)) dut (
      .clk         (clk),
      .rst         (rst),
      .output_c    (output_c),
      .sop_c       (sop_c),
      .bias_we     (bias_we),
      .bias_addr   (bias_addr),
      .bias_data   (bias_data),
      .class_out   (class_out),
      .class_valid (class_valid),
      .busy        (busy),
      .err_drop    (err_drop),
`ifdef SVM_VOTE_STATUS_EN
      .vote_max    (vote_max),
      .vote_tie    (vote_tie),
`endif
      .state_dbg   (state_dbg)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // True when sum+bias is strictly negative (vote goes to class j).
   function automatic bit model_neg(input logic [31:0] s, input logic [31:0] b);
      int ms, mb;
      ms = $signed(s[29:0]);
      mb = $signed(b[29:0]);
      if (s[31] && b[31]) return 1'b0;
      if (s[31]) return b[30];
      if (b[31]) return s[30];
      if (s[30] == b[30]) return s[30];
      if (ms > mb) return s[30];
      if (mb > ms) return b[30];
      return 1'b0;
   endfunction

   function automatic void pair_of(input int p, output int pi, output int pj);
      int k;
      k = 0;
      pi = 0;
      pj = 1;
      for (int a = 0; a < N; a++)
         for (int b = a + 1; b < N; b++) begin
            if (k == p) begin
               pi = a;
               pj = b;
            end
            k++;
         end
   endfunction

   // exp_q entries pack {tie, max, class}
   logic [2*CWB:0] exp_q[$];
   logic [2*CWB:0] m_hold;
   int             cyc = 0;
   int             busy_until = -1;
   int             valid_at = -1;
   bit             m_err;
   bit             live = 1'b0;
   int             m_pair;
   int             m_votes [N];
   logic [31:0]    m_bias [P];

   always @(posedge clk) begin
      int pi, pj, best;
      bit tie_f;
      if (rst) begin
         busy_until = -1;
         valid_at   = -1;
         m_err      = 1'b0;
         m_pair     = 0;
         m_hold     = '0;
         exp_q.delete();
         foreach (m_votes[c]) m_votes[c] = 0;
         foreach (m_bias[p]) m_bias[p] = 32'h8000_0000;
         live = 1'b1;
      end else begin
         if (bias_we && int'(bias_addr) < P) m_bias[bias_addr] = bias_data;
         if (sop_c) begin
            if (cyc <= busy_until) m_err = 1'b1;
            else begin
               pair_of(m_pair, pi, pj);
               if (model_neg(output_c, m_bias[m_pair])) m_votes[pj]++;
               else m_votes[pi]++;
               if (m_pair == P - 1) begin
                  best = 0;
                  for (int c = 1; c < N; c++)
                     if (m_votes[c] > m_votes[best]) best = c;
                  tie_f = 1'b0;
                  for (int c = 0; c < N; c++)
                     if (c != best && m_votes[c] == m_votes[best]) tie_f = 1'b1;
                  exp_q.push_back({tie_f, CWB'(m_votes[best]), CWB'(best)});
                  foreach (m_votes[c]) m_votes[c] = 0;
                  m_pair     = 0;
                  busy_until = cyc + 3 + N;
                  valid_at   = cyc + 3 + N;
               end else begin
                  m_pair++;
                  busy_until = cyc + 2;
               end
            end
         end
      end
      cyc++;
      if (cyc == valid_at && exp_q.size() > 0) m_hold = exp_q.pop_front();
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (live && !rst) begin
         check("busy", 32'(busy), 32'(cyc <= busy_until));
         check("class_valid", 32'(class_valid), 32'(cyc == valid_at));
         check("err_drop", 32'(err_drop), 32'(m_err));
         check("class_out", 32'(class_out), 32'(m_hold[CWB-1:0]));
`ifdef SVM_VOTE_STATUS_EN
         check("vote_max", 32'(vote_max), 32'(m_hold[2*CWB-1:CWB]));
         check("vote_tie", 32'(vote_tie), 32'(m_hold[2*CWB]));
`endif
      end
   end

   // ---------------- driver tasks ----------------
   logic [31:0] drv_bias [P];

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      sop_c   = 1'b0;
      bias_we = 1'b0;
      tick(1);
      rst = 1'b0;
      foreach (drv_bias[p]) drv_bias[p] = 32'h8000_0000;
   endtask

   task automatic write_bias(input int p, input logic [31:0] v);
      bias_we   = 1'b1;
      bias_addr = PWB'(p);
      bias_data = v;
      tick(1);
      bias_we = 1'b0;
      drv_bias[p] = v;
   endtask

   task automatic send_sum(input logic [31:0] v);
      sop_c    = 1'b1;
      output_c = v;
      tick(1);
      sop_c = 1'b0;
   endtask

   task automatic expect_result(input string name, input int cls, input int mx, input int tie_f);
      check({name, "_class"}, 32'(class_out), 32'(cls));
`ifdef SVM_VOTE_STATUS_EN
      check({name, "_max"}, 32'(vote_max), 32'(mx));
      check({name, "_tie"}, 32'(vote_tie), 32'(tie_f));
`else
      if (mx < 0 || tie_f < 0) $display("note: bad literal in %s", name);
`endif
   endtask

   // Three sums at minimum spacing; class_valid must land exactly at t+3+N.
   task automatic run_round(input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] s2);
      send_sum(s0);
      tick(2);
      send_sum(s1);
      tick(2);
      send_sum(s2);
      tick(N + 1);
      check("valid_early", 32'(class_valid), 32'd0);
      tick(1);
      check("valid_latency", 32'(class_valid), 32'd1);
   endtask

   function automatic logic [31:0] rand_bias();
      logic [29:0] m;
      m = 30'($urandom_range(0, 40)) - 30'd20;
      if ($urandom_range(0, 3) == 0) return 32'h8000_0000;
      return {1'b0, 1'($urandom_range(0, 1)), m};
   endfunction

   function automatic logic [31:0] rand_sum(input logic [31:0] b);
      logic [29:0] m;
      m = 30'($urandom_range(0, 40)) - 30'd20;
      case ($urandom_range(0, 5))
         0: return 32'h8000_0000;
         1: return {1'b0, ~b[30], b[29:0]};
         2: return {1'b0, b[30], b[29:0]};
         3: return {1'b0, 1'($urandom_range(0, 1)), 30'($urandom)};
         default: return {1'b0, 1'($urandom_range(0, 1)), m};
      endcase
   endfunction

   task automatic random_round();
      int abort_p, k;
      bit inj;
      if ($urandom_range(0, 1) == 1)
         for (int p = 0; p < P; p++) write_bias(p, rand_bias());
      abort_p = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, P - 1)) : -1;
      inj     = ($urandom_range(0, 5) == 0);
      for (int p = 0; p < P; p++) begin
         send_sum(rand_sum(drv_bias[p]));
         if (p == abort_p) begin
            tick($urandom_range(0, 3));
            do_reset();
            return;
         end
         if (p < P - 1) tick($urandom_range(2, 5));
         else if (inj) begin
            k = $urandom_range(0, N + 2);
            tick(k);
            send_sum($urandom);
            tick(N + 2 - k + $urandom_range(0, 4));
         end else begin
            tick(N + 3 + $urandom_range(0, 4));
         end
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      foreach (drv_bias[p]) drv_bias[p] = 32'h8000_0000;
      tick(2);
      rst = 1'b0;
      check("rst_class_out", 32'(class_out), 32'd0);
      check("rst_class_valid", 32'(class_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_err_drop", 32'(err_drop), 32'd0);
      tick(1);

      check("pin_opp_sign", 32'(model_neg(32'h0000_3000, 32'h4000_4000)), 32'd1);
      check("pin_zero_sum", 32'(model_neg(32'h8000_0000, 32'h4000_0100)), 32'd1);
      check("pin_zero_zero", 32'(model_neg(32'h8000_0000, 32'h8000_0000)), 32'd0);
      check("pin_equal_mag", 32'(model_neg(32'h0000_2000, 32'h4000_2000)), 32'd0);
      check("pin_signed_mag", 32'(model_neg(32'h3FFF_FFFB, 32'h4000_0003)), 32'd1);

      // all positive: votes 2/1/0
      run_round(32'h0000_1000, 32'h0000_1000, 32'h0000_1000);
      expect_result("all_pos", 0, 2, 0);
      tick(2);

      // pair0 -> 1, pair1 -> 0, pair2 -> 2: votes 1/1/1
      write_bias(0, 32'h4000_4000);
      run_round(32'h0000_3000, 32'h0000_1000, 32'h4000_1000);
      expect_result("opp_sign", 0, 1, 1);
      tick(2);

      // equal magnitudes, opposite signs: every pair ties -> class i
      do_reset();
      for (int p = 0; p < P; p++) write_bias(p, 32'h4000_2000);
      run_round(32'h0000_2000, 32'h0000_2000, 32'h0000_2000);
      expect_result("equal_mag", 0, 2, 0);
      tick(2);

      // three-way tie: pairs vote 0,2,1
      do_reset();
      run_round(32'h0000_0100, 32'h4000_0100, 32'h0000_0100);
      expect_result("three_way", 0, 1, 1);
      tick(2);

      // zero sums: pair0 takes the negative bias -> j, others tie -> i
      do_reset();
      write_bias(0, 32'h4000_0100);
      run_round(32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
      expect_result("zero_sum", 1, 2, 0);
      tick(2);

      // sop during ARGMAX is dropped and flagged
      send_sum(32'h8000_0000);
      tick(2);
      send_sum(32'h8000_0000);
      tick(2);
      send_sum(32'h8000_0000);
      tick(3);
      send_sum(32'h4000_7000);
      tick(1);
      check("drop_valid", 32'(class_valid), 32'd1);
      expect_result("drop_result", 1, 2, 0);
      check("drop_err", 32'(err_drop), 32'd1);
      tick(2);
      run_round(32'h0000_1000, 32'h0000_1000, 32'h0000_1000);
      expect_result("after_drop", 0, 2, 0);
      check("err_sticky", 32'(err_drop), 32'd1);
      tick(2);

      do_reset();
      check("err_cleared", 32'(err_drop), 32'd0);
      tick(1);

      for (int r = 0; r < 120; r++) random_round();
      tick(N + 8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
